cellram_arbiter: RTL and testbench

CELLRAM_ARBITER -- requirements
Module: cellram_arbiter

---
 rtl/cellram_arbiter.sv | 125 ++++++++++++
 tb/tb_cellram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellram_arbiter.sv
// Two-client arbiter for a single CellularRAM port: latches one client's
// request, issues a one-cycle strobe, waits out cr_wait, then pulses done.
module cellram_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] c0_addr,
  input  logic [15:0] c0_data_in,
  input  logic        c0_read,
  input  logic        c0_write,
  output logic        c0_wait,
  output logic        c0_done,
  output logic [15:0] c0_data_out,
  input  logic [23:0] c1_addr,
  input  logic [15:0] c1_data_in,
  input  logic        c1_read,
  input  logic        c1_write,
  output logic        c1_wait,
  output logic        c1_done,
  output logic [15:0] c1_data_out,
  output logic [23:0] cr__addr,
  output logic [15:0] cr__data_in,
  output logic        cr__read,
  output logic        cr__write,
  input  logic        cr_wait,
  input  logic [15:0] cr_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t state, state_next;
  logic   grant;
  logic   op_read;
  logic   last;
  logic   req0, req1;
  logic   pick;
  logic   pick_read;

  assign req0 = c0_read | c0_write;
  assign req1 = c1_read | c1_write;

  // A tie goes to the client not served last in round-robin mode, else to client 0.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = (ROUND_ROBIN != 0) ? ~last : 1'b0;
    end else begin
      pick = ~req0;
    end
    pick_read = pick ? c1_read : c0_read;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cr__read   = 1'b0;
    cr__write  = 1'b0;
    c0_done    = 1'b0;
    c1_done    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cr__read   = op_read;
        cr__write  = ~op_read;
        state_next = BUSY;
      end
      BUSY: begin
        if (!cr_wait) begin
          state_next = DONE;
        end
      end
      DONE: begin
        c0_done    = ~grant;
        c1_done    = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= 1'b0;
      op_read     <= 1'b0;
      last        <= 1'b1;
      cr__addr    <= '0;
      cr__data_in <= '0;
      c0_data_out <= '0;
      c1_data_out <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        grant       <= pick;
        op_read     <= pick_read;
        cr__addr    <= pick ? c1_addr : c0_addr;
        cr__data_in <= pick ? c1_data_in : c0_data_in;
      end
      if (state == BUSY && !cr_wait && op_read) begin
        if (grant) begin
          c1_data_out <= cr_rdata;
        end else begin
          c0_data_out <= cr_rdata;
        end
      end
      if (state == DONE) begin
        last <= grant;
      end
    end
  end

  assign c0_wait = req0 & ~c0_done;
  assign c1_wait = req1 & ~c1_done;

endmodule

// File: tb/tb_cellram_arbiter.sv
// Bench for cellram_arbiter: a round-robin and a fixed-priority instance,
// checked every cycle against a transaction-level model plus directed scenarios.
module tb_cellram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [23:0] addr_i [2][2];
  logic [15:0] wdat   [2][2];
  logic        rd_i   [2][2];
  logic        wr_i   [2][2];
  logic        wt_o   [2][2];
  logic        dn_o   [2][2];
  logic [15:0] dout_o [2][2];
  logic [23:0] cra    [2];
  logic [15:0] crd    [2];
  logic        crr    [2];
  logic        crw    [2];
  logic        crwait [2];
  logic [15:0] rdata  [2];
  int          cnt    [2];
  int          kval   [2];

  cellram_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst),
    .c0_addr(addr_i[0][0]), .c0_data_in(wdat[0][0]), .c0_read(rd_i[0][0]), .c0_write(wr_i[0][0]),
    .c0_wait(wt_o[0][0]), .c0_done(dn_o[0][0]), .c0_data_out(dout_o[0][0]),
    .c1_addr(addr_i[0][1]), .c1_data_in(wdat[0][1]), .c1_read(rd_i[0][1]), .c1_write(wr_i[0][1]),
    .c1_wait(wt_o[0][1]), .c1_done(dn_o[0][1]), .c1_data_out(dout_o[0][1]),
    .cr__addr(cra[0]), .cr__data_in(crd[0]), .cr__read(crr[0]), .cr__write(crw[0]),
    .cr_wait(crwait[0]), .cr_rdata(rdata[0])
  );

  cellram_arbiter #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst(rst),
    .c0_addr(addr_i[1][0]), .c0_data_in(wdat[1][0]), .c0_read(rd_i[1][0]), .c0_write(wr_i[1][0]),
    .c0_wait(wt_o[1][0]), .c0_done(dn_o[1][0]), .c0_data_out(dout_o[1][0]),
    .c1_addr(addr_i[1][1]), .c1_data_in(wdat[1][1]), .c1_read(rd_i[1][1]), .c1_write(wr_i[1][1]),
    .c1_wait(wt_o[1][1]), .c1_done(dn_o[1][1]), .c1_data_out(dout_o[1][1]),
    .cr__addr(cra[1]), .cr__data_in(crd[1]), .cr__read(crr[1]), .cr__write(crw[1]),
    .cr_wait(crwait[1]), .cr_rdata(rdata[1])
  );

  // Downstream memory: busy during the strobe and for K-1 cycles after it.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) cnt[i] <= 0;
      else if (crr[i] || crw[i]) cnt[i] <= kval[i] - 1;
      else if (cnt[i] != 0) cnt[i] <= cnt[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) crwait[i] = crr[i] | crw[i] | (cnt[i] != 0);
  end

  // Model: phase 0 none, 1 strobe cycle, 2 waiting on memory, 3 completion cycle.
  int          m_ph   [2];
  int          m_cli  [2];
  int          m_last [2];
  logic        m_rd   [2];
  logic [23:0] m_addr [2];
  logic [15:0] m_data [2];
  logic [15:0] m_dout [2][2];

  int vectors = 0;
  int miscompares = 0;
  bit rand_en = 1'b0;
  bit auto_drop = 1'b1;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, want, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("cr_read", i, 32'(crr[i]), 32'(m_ph[i] == 1 && m_rd[i]));
      chk("cr_write", i, 32'(crw[i]), 32'(m_ph[i] == 1 && !m_rd[i]));
      chk("cr_addr", i, 32'(cra[i]), 32'(m_addr[i]));
      chk("cr_data_in", i, 32'(crd[i]), 32'(m_data[i]));
      for (int j = 0; j < 2; j++) begin
        logic edn;
        edn = (m_ph[i] == 3 && m_cli[i] == j);
        chk("done", i, 32'(dn_o[i][j]), 32'(edn));
        chk("data_out", i, 32'(dout_o[i][j]), 32'(m_dout[i][j]));
        chk("wait", i, 32'(wt_o[i][j]), 32'((rd_i[i][j] | wr_i[i][j]) & !edn));
      end
    end
  endtask

  task automatic step_model();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ph[i] = 0; m_cli[i] = 0; m_last[i] = 1; m_rd[i] = 1'b0;
        m_addr[i] = '0; m_data[i] = '0; m_dout[i][0] = '0; m_dout[i][1] = '0;
      end else begin
        case (m_ph[i])
          0: begin
            logic r0, r1;
            int c;
            r0 = rd_i[i][0] | wr_i[i][0];
            r1 = rd_i[i][1] | wr_i[i][1];
            if (r0 || r1) begin
              if (r0 && r1) c = (i == 0) ? 1 - m_last[i] : 0;
              else c = r0 ? 0 : 1;
              m_cli[i] = c;
              m_rd[i] = rd_i[i][c];
              m_addr[i] = addr_i[i][c];
              m_data[i] = wdat[i][c];
              m_ph[i] = 1;
            end
          end
          1: m_ph[i] = 2;
          2: if (!crwait[i]) begin
            m_ph[i] = 3;
            if (m_rd[i]) m_dout[i][m_cli[i]] = rdata[i];
          end
          default: begin
            m_last[i] = m_cli[i];
            m_ph[i] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic client_update();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        bit dropped;
        dropped = 1'b0;
        if (auto_drop && dn_o[i][j] === 1'b1 && (!rand_en || $urandom_range(0, 3) != 0)) begin
          rd_i[i][j] = 1'b0; wr_i[i][j] = 1'b0; dropped = 1'b1;
        end
        if (rand_en && !dropped && !rd_i[i][j] && !wr_i[i][j] && $urandom_range(0, 2) == 0) begin
          int op;
          op = int'($urandom_range(1, 3));
          addr_i[i][j] = 24'($urandom);
          wdat[i][j] = 16'($urandom);
          rd_i[i][j] = (op != 2);
          wr_i[i][j] = (op >= 2);
        end
      end
      if (rand_en) begin
        rdata[i] = 16'($urandom);
        kval[i] = int'($urandom_range(1, 5));
      end
    end
    if (rand_en) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
    end
  endtask

  task automatic cyc();
    step_model();
    @(negedge clk);
    check_all();
    client_update();
  endtask

  task automatic run_txn(input int i, input int j, output int strobe_n, output int nrd,
                         output int nwr, output int fall_n, output int done_n,
                         output logic [23:0] saddr);
    strobe_n = 0; nrd = 0; nwr = 0; fall_n = 0; done_n = 0; saddr = '0;
    for (int n = 1; n <= 40 && done_n == 0; n++) begin
      cyc();
      if (crr[i] === 1'b1 || crw[i] === 1'b1) begin
        if (crr[i] === 1'b1) nrd++;
        if (crw[i] === 1'b1) nwr++;
        if (strobe_n == 0) begin
          strobe_n = n;
          saddr = cra[i];
        end
      end else if (strobe_n != 0 && fall_n == 0 && crwait[i] === 1'b0) begin
        fall_n = n;
      end
      if (dn_o[i][j] === 1'b1) done_n = n;
    end
  endtask

  initial begin
    int sn, nr, nw, fn, dnn, seen, c0g, c1g, wlow;
    logic [23:0] sa;
    int order [4];
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        addr_i[i][j] = '0; wdat[i][j] = '0; rd_i[i][j] = 1'b0; wr_i[i][j] = 1'b0;
      end
      rdata[i] = '0;
      kval[i] = 1;
    end
    rst = 1'b1;
    cyc();
    chk("reset_addr", 0, 32'(cra[0]), 32'h0);
    chk("reset_dout", 1, 32'(dout_o[1][1]), 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Single read, K=6
    kval[0] = 6; rdata[0] = 16'hBEEF;
    addr_i[0][0] = 24'h000010; rd_i[0][0] = 1'b1;
    run_txn(0, 0, sn, nr, nw, fn, dnn, sa);
    chk("read_strobe_cycle", 0, 32'(sn), 32'd1);
    chk("read_strobe_count", 0, 32'(nr), 32'd1);
    chk("read_addr", 0, 32'(sa), 32'h000010);
    chk("read_wait_fall", 0, 32'(fn), 32'd7);
    chk("read_done_cycle", 0, 32'(dnn), 32'd8);
    chk("read_data", 0, 32'(dout_o[0][0]), 32'hBEEF);
    cyc();

    // Read and write together is a read
    kval[0] = 2;
    addr_i[0][0] = 24'h000055; wdat[0][0] = 16'hAAAA; rd_i[0][0] = 1'b1; wr_i[0][0] = 1'b1;
    run_txn(0, 0, sn, nr, nw, fn, dnn, sa);
    chk("rw_read_pulses", 0, 32'(nr), 32'd1);
    chk("rw_write_pulses", 0, 32'(nw), 32'd0);
    chk("rw_done_cycle", 0, 32'(dnn), 32'd4);
    cyc();

    // Minimum busy write leaves data_out alone
    kval[0] = 1; rdata[0] = 16'h1111;
    addr_i[0][0] = 24'h000030; wdat[0][0] = 16'h0077; wr_i[0][0] = 1'b1;
    run_txn(0, 0, sn, nr, nw, fn, dnn, sa);
    chk("k1_write_pulses", 0, 32'(nw), 32'd1);
    chk("k1_done_cycle", 0, 32'(dnn), 32'd3);
    cyc();
    chk("k1_idle_done", 0, 32'(dn_o[0][0]), 32'd0);
    chk("k1_dout_kept", 0, 32'(dout_o[0][0]), 32'hBEEF);

    // Round-robin alternation with both clients held
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    auto_drop = 1'b0; kval[0] = 2;
    addr_i[0][0] = 24'h000020; wdat[0][0] = 16'h1234; wr_i[0][0] = 1'b1;
    addr_i[0][1] = 24'h000040; rd_i[0][1] = 1'b1;
    seen = 0;
    for (int n = 0; n < 60 && seen < 4; n++) begin
      cyc();
      if (crr[0] === 1'b1 || crw[0] === 1'b1) begin
        order[seen] = (cra[0] == 24'h000020 && crw[0] === 1'b1) ? 0 :
                      (cra[0] == 24'h000040 && crr[0] === 1'b1) ? 1 : 9;
        seen++;
      end
    end
    chk("rr_grants_seen", 0, 32'(seen), 32'd4);
    for (int k = 0; k < 4; k++) chk("rr_order", 0, 32'(order[k]), 32'(k % 2));
    auto_drop = 1'b1;
    repeat (20) cyc();

    // Fixed priority starves client 1 while client 0 keeps requesting
    auto_drop = 1'b0; kval[1] = 1;
    addr_i[1][0] = 24'h000100; rd_i[1][0] = 1'b1;
    addr_i[1][1] = 24'h000200; wdat[1][1] = 16'h5A5A; wr_i[1][1] = 1'b1;
    c0g = 0; c1g = 0; wlow = 0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (crr[1] === 1'b1 && cra[1] == 24'h000100) c0g++;
      if (crw[1] === 1'b1) c1g++;
      if (wt_o[1][1] !== 1'b1) wlow++;
    end
    chk("fp_c0_grants", 1, 32'(c0g), 32'd8);
    chk("fp_c1_grants", 1, 32'(c1g), 32'd0);
    chk("fp_c1_wait_low", 1, 32'(wlow), 32'd0);
    auto_drop = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (dn_o[1][1] === 1'b1) seen++;
    end
    chk("fp_c1_served_later", 1, 32'(seen), 32'd1);

    // Reset during BUSY of a client 1 read
    kval[0] = 4; rdata[0] = 16'h4321;
    addr_i[0][1] = 24'h000099; rd_i[0][1] = 1'b1;
    seen = 0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("rst_no_done", 0, 32'(dn_o[0][1]), 32'd0);
    chk("rst_read", 0, 32'(crr[0]), 32'd0);
    chk("rst_addr", 0, 32'(cra[0]), 32'h0);
    chk("rst_dout0", 0, 32'(dout_o[0][0]), 32'h0);
    cyc();
    rst = 1'b0;
    run_txn(0, 1, sn, nr, nw, fn, dnn, sa);
    chk("rst_reissue_read", 0, 32'(nr), 32'd1);
    chk("rst_reissue_addr", 0, 32'(sa), 32'h000099);
    chk("rst_reissue_done", 0, 32'(dnn), 32'd6);
    chk("rst_reissue_data", 0, 32'(dout_o[0][1]), 32'h4321);
    cyc();

    // Randomized traffic on both instances
    rand_en = 1'b1;
    repeat (4000) cyc();
    rand_en = 1'b0;
    rst = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
